// File: rtl/cabac_ctx_pkg.sv
// Context word layout and HEVC LPS state-transition table shared by the
// CABAC context store and its update engine.
package cabac_ctx_pkg;

  localparam int CTX_W    = 7;
  localparam int MPS_BIT  = 6;
  localparam int PSTATE_W = 6;

  typedef struct packed {
    logic                mps;
    logic [PSTATE_W-1:0] pstate;
  } ctx_t;

  localparam logic [PSTATE_W-1:0] TRANS_IDX_LPS [64] = '{
    6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
    6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
    6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
    6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
    6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
    6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
    6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
    6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
  };

endpackage

// File: rtl/cabac_ctx_next.sv
// Combinational HEVC context transition: {ctx, bin} -> {next ctx, lps}.
module cabac_ctx_next
  import cabac_ctx_pkg::*;
(
  input  ctx_t ctx,
  input  logic bin,
  output ctx_t next_ctx,
  output logic lps
);

  // MPS path saturates at 62 (63 is the terminate state); LPS path uses the table
  always_comb begin
    next_ctx = ctx;
    lps      = bin ^ ctx.mps;
    if (lps) begin
      next_ctx.pstate = TRANS_IDX_LPS[ctx.pstate];
      if (ctx.pstate == 6'd0) begin
        next_ctx.mps = ~ctx.mps;
      end else begin
        next_ctx.mps = ctx.mps;
      end
    end else begin
      if (ctx.pstate <= 6'd61) begin
        next_ctx.pstate = ctx.pstate + 6'd1;
      end else begin
        next_ctx.pstate = ctx.pstate;
      end
    end
  end

endmodule

// File: rtl/cabac_ctx_update_pipe.sv
// CABAC context store with 2-cycle read/update/writeback pipeline.
// Optional macro CABAC_CTX_FWD_EN: forward same-index back-to-back bins instead of stalling.
module cabac_ctx_update_pipe
  import cabac_ctx_pkg::*;
#(
  parameter int NUM_CTX = 128,
  parameter int CTX_AW  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_valid,
  output logic                init_ready,
  input  logic [CTX_AW-1:0]   init_idx,
  input  logic [CTX_W-1:0]    init_ctx,
  input  logic                bin_valid,
  output logic                bin_ready,
  input  logic [CTX_AW-1:0]   bin_idx,
  input  logic                bin_val,
  output logic                out_valid,
  output logic [CTX_AW-1:0]   out_idx,
  output logic [PSTATE_W-1:0] out_pstate,
  output logic                out_mps,
  output logic                out_lps
);

  function automatic logic [2**CTX_AW-1:0] idx_ok_mask();
    logic [2**CTX_AW-1:0] m;
    for (int i = 0; i < 2**CTX_AW; i++) begin
      m[i] = (i < NUM_CTX);
    end
    return m;
  endfunction

  localparam logic [2**CTX_AW-1:0] IDX_OK = idx_ok_mask();

  ctx_t                mem_r [NUM_CTX];
  ctx_t                rd_data_r;
  logic                s1_valid_r;
  logic [CTX_AW-1:0]   s1_idx_r;
  logic                s1_bin_r;
  ctx_t                ctx_s;
  ctx_t                next_ctx_s;
  logic                lps_s;
  logic                fwd_hit_s;
  logic                bin_ready_s;
  logic                bin_fire_s;
  logic                init_ready_s;
  logic                init_fire_s;
  logic                out_valid_r;
  logic [CTX_AW-1:0]   out_idx_r;
  logic [PSTATE_W-1:0] out_pstate_r;
  logic                out_mps_r;
  logic                out_lps_r;

`ifdef CABAC_CTX_FWD_EN
  assign bin_ready_s = ~init_valid;
`else
  assign bin_ready_s = ~init_valid & ~(s1_valid_r & (bin_idx == s1_idx_r));
`endif
  assign bin_fire_s   = bin_valid & bin_ready_s;
  assign init_ready_s = ~s1_valid_r & ~bin_fire_s;
  assign init_fire_s  = init_valid & init_ready_s;

  // Context array: init and S1 writeback never coincide since init waits for S1 to drain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        mem_r[i] <= '0;
      end
    end else if (init_fire_s && IDX_OK[init_idx]) begin
      mem_r[init_idx] <= init_ctx;
    end else if (s1_valid_r && IDX_OK[s1_idx_r]) begin
      mem_r[s1_idx_r] <= next_ctx_s;
    end
  end

  // Registered read (read-first against a same-edge writeback) and S1 stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= '0;
      s1_valid_r <= 1'b0;
      s1_idx_r   <= '0;
      s1_bin_r   <= 1'b0;
    end else begin
      s1_valid_r <= bin_fire_s;
      if (bin_fire_s) begin
        rd_data_r <= IDX_OK[bin_idx] ? mem_r[bin_idx] : ctx_t'(7'd0);
        s1_idx_r  <= bin_idx;
        s1_bin_r  <= bin_val;
      end
    end
  end

`ifdef CABAC_CTX_FWD_EN
  logic              fwd_valid_r;
  logic [CTX_AW-1:0] fwd_idx_r;
  ctx_t              fwd_ctx_r;

  // Holds the most recent writeback so a directly following same-index read can bypass the array
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_r <= 1'b0;
      fwd_idx_r   <= '0;
      fwd_ctx_r   <= '0;
    end else if (s1_valid_r && IDX_OK[s1_idx_r]) begin
      fwd_valid_r <= 1'b1;
      fwd_idx_r   <= s1_idx_r;
      fwd_ctx_r   <= next_ctx_s;
    end else if (init_fire_s && (init_idx == fwd_idx_r)) begin
      fwd_valid_r <= 1'b0;
    end
  end

  assign fwd_hit_s = fwd_valid_r & (fwd_idx_r == s1_idx_r);
`else
  assign fwd_hit_s = 1'b0;
`endif

  // Context seen by S1: forwarded writeback or array read data
  always_comb begin
    ctx_s = rd_data_r;
`ifdef CABAC_CTX_FWD_EN
    if (fwd_hit_s) begin
      ctx_s = fwd_ctx_r;
    end else begin
      ctx_s = rd_data_r;
    end
`endif
  end

  cabac_ctx_next u_next (
    .ctx      (ctx_s),
    .bin      (s1_bin_r),
    .next_ctx (next_ctx_s),
    .lps      (lps_s)
  );

  // Output register carries the pre-update context
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_idx_r    <= '0;
      out_pstate_r <= '0;
      out_mps_r    <= 1'b0;
      out_lps_r    <= 1'b0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_idx_r    <= s1_idx_r;
        out_pstate_r <= ctx_s[PSTATE_W-1:0];
        out_mps_r    <= ctx_s[MPS_BIT];
        out_lps_r    <= lps_s;
      end
    end
  end

  assign init_ready = init_ready_s;
  assign bin_ready  = bin_ready_s;
  assign out_valid  = out_valid_r;
  assign out_idx    = out_idx_r;
  assign out_pstate = out_pstate_r;
  assign out_mps    = out_mps_r;
  assign out_lps    = out_lps_r;

endmodule

// File: doc/cabac_ctx_update_pipe.md
Name: cabac_ctx_update_pipe

Overview:
- Parametrised context-model store plus update engine for the CABAC bin encoder.
- Holds NUM_CTX 7-bit contexts {mps, pstate[5:0]} in a synchronous-read 1R1W array.
- Accepts one context-coded bin per cycle and presents the pre-update context to the arithmetic coder (rLPS lookup).
- Writes the HEVC-updated context back; back-to-back same-context bins are resolved by forwarding or by a stall.

Parameters:
NUM_CTX, 128, number of context entries
CTX_AW, 7, context index width; NUM_CTX <= 2**CTX_AW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
init_valid  in  1  raw context write request
init_ready  out  1  init write accepted when init_valid && init_ready
init_idx  in  CTX_AW  init write index
init_ctx  in  7  init value {mps, pstate}
bin_valid  in  1  bin request
bin_ready  out  1  bin accepted when bin_valid && bin_ready
bin_idx  in  CTX_AW  context index of bin
bin_val  in  1  bin value
out_valid  out  1  one-cycle pulse per accepted bin; downstream always accepts
out_idx  out  CTX_AW  context index
out_pstate  out  6  pstate before update
out_mps  out  1  mps before update
out_lps  out  1  1 when bin_val != mps

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: all array entries = 7'd0; S1 invalid; out_valid/out_idx/out_pstate/out_mps/out_lps = 0; forward register invalid.
- Pipeline:
  - Cycle T: accept; RAM read address registered.
  - Cycle T+1 (S1): read data plus forward mux gives ctx; next ctx computed; written at end of T+1; out_* registered.
  - Cycle T+2: out_valid = 1 with the pre-update ctx. Latency is 2 cycles; throughput 1 bin/cycle.
- Transition rule (the two entries of the ctx are pstate s and mps m):
  - MPS path (bin == m): s' = s+1 for s <= 61; 62 stays 62; 63 stays 63.
  - LPS path: s' = transIdxLps[s], the HEVC table (0,0,1,2,2,4,4,5,6,7,8,9,9,11,11,12,13,13,15,15,16,16,18,18,19,19,21,21,22,22,23,24,24,25,26,26,27,27,28,29,29,30,30,30,31,32,32,33,33,33,34,34,35,35,35,36,36,36,37,37,37,38,38,63).
  - m' = ~m only on LPS with s == 0.
- RAM is read-first: a read and a write to the same address on the same edge return old data.
- Hazard case: bin B accepted at T+1 with idx equal to bin A accepted at T.
  - B's read is stale.
  - The forward register captures {idx, next ctx} of every S1 writeback.
  - S1 selects the forwarded value when the forward register is valid and its idx equals S1 idx.
  - An init write to that idx invalidates the forward register.
- Init writes:
  - init_ready = ~S1 valid && ~bin_valid_accepting; init has priority, so bin_ready = 0 while init_valid.
  - Init writes on the accept edge.
  - The init port is never stalled more than 1 cycle.
- Indices >= NUM_CTX: the write is dropped; the output reports ctx 0 (array read returns 0).
- Reset mid-operation: S1 and out pipeline flushed; no writeback happens on the reset cycle.

Optional Feature:
- Macro: CABAC_CTX_FWD_EN.
- Defined: forwarding as above; bin_ready = ~init_valid.
- Undefined:
  - No forward register.
  - bin_ready = ~init_valid && ~(S1 valid && bin_idx == S1 idx), so a same-index back-to-back bin stalls exactly 1 cycle.
  - Output values are identical, only timing differs.

Decomposition:
- Package cabac_ctx_pkg holds:
  - CTX_W = 7.
  - Typedef/field positions: MPS bit 6, pstate [5:0].
  - The 64-entry transIdxLps constant.
- Sub-module cabac_ctx_next: combinational {ctx, bin} -> {next ctx, lps}, instantiated once in S1.

Test Plan:
- Reset check: after rst, bin idx 5 val 0 -> out pstate 0, mps 0, lps 0. Next bin idx 5 val 0 -> pstate 1.
- MPS flip: init idx 2 = {0, 0}; bin val 1 -> out lps 1, pstate 0, mps 0; next bin idx 2 -> out mps 1, pstate 0.
- Back-to-back same index: init idx 3 = {0, 10}; bins idx 3 val 0 on 3 consecutive cycles:
  - Outputs show pstate 10, 11, 12; final read gives 13.
  - With CABAC_CTX_FWD_EN: outputs on 3 consecutive cycles.
  - Without it: bin_ready drops 1 cycle between each bin.
- Saturation and LPS: init idx 7 = {1, 62}; bin val 1 -> pstate stays 62. Then bin val 0 -> lps 1, next pstate 38.
- Init/bin conflict: init_valid with bin_valid in the same cycle -> init accepted first, bin_ready = 0; bin then sees the init value. Reset asserted while S1 is valid -> no writeback, out_valid = 0.
